gate_resp_checker: RTL and testbench

- Self-checking responder for the basic gate bank: Not, Nand, And, Or and Xor.
- Drives the shared a/b stimulus by sweeping all four input vectors.
- Samples the five gate outputs after a programmable settle time and compares them against the truth table.
- Reports an error count, a per-gate sticky fail mask, and a start/busy/done handshake, so a gate bank can be verified in hardware without a $monitor bench.

---
 rtl/gate_resp_checker_if.sv | 48 ++++
 rtl/gate_resp_checker.sv | 186 ++++++++++++++++++
 tb/tb_gate_resp_checker.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_resp_checker_if.sv
// rtl/gate_resp_checker_if.sv - gate bank stimulus/response bus and run handshake for gate_resp_checker

interface gate_resp_checker_if;
    // run handshake
    logic start;
    logic busy;
    logic done;
    logic pass;
    // stimulus towards the gate bank
    logic a_out;
    logic b_out;
    // observed gate bank outputs
    logic anot;
    logic abnand;
    logic aband;
    logic abor;
    logic abxor;

    // checker side
    modport master (
        input  start,
        input  anot,
        input  abnand,
        input  aband,
        input  abor,
        input  abxor,
        output busy,
        output done,
        output pass,
        output a_out,
        output b_out
    );

    // gate bank / run controller side
    modport slave (
        output start,
        output anot,
        output abnand,
        output aband,
        output abor,
        output abxor,
        input  busy,
        input  done,
        input  pass,
        input  a_out,
        input  b_out
    );
endinterface

// File: rtl/gate_resp_checker.sv
// rtl/gate_resp_checker.sv - truth-table checker for a Not/Nand/And/Or/Xor gate bank (optional GATE_CHK_FIRST_FAIL_EN first-failure capture)

module gate_resp_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    gate_resp_checker_if.master   bus,
    output logic [ERR_W-1:0]      err_count,
    output logic [4:0]            fail_mask,
    output logic [1:0]            cur_vec
`ifdef GATE_CHK_FIRST_FAIL_EN
    ,
    output logic                  first_fail_valid,
    output logic [1:0]            first_fail_vec,
    output logic [4:0]            first_fail_obs
`endif
);

    // Counter widths only need to hold the reload values (N-1).
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PASS_LAST   = PW'(PASSES - 1);

    // Out-of-range configurations are rejected at elaboration.
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("gate_resp_checker: SETTLE_CYCLES must be at least 1");
    end
    if (PASSES < 1) begin : g_bad_passes
        $error("gate_resp_checker: PASSES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        vec_q, vec_d;
    logic [SW-1:0]     scnt_q, scnt_d;
    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [4:0]        mask_q, mask_d;
`ifdef GATE_CHK_FIRST_FAIL_EN
    logic              ffv_q, ffv_d;
    logic [1:0]        ffvec_q, ffvec_d;
    logic [4:0]        ffobs_q, ffobs_d;
`endif

    logic              a, b;
    logic [4:0]        expected;
    logic [4:0]        observed;
    logic [4:0]        mism;
    logic [2:0]        pop;
    logic [ERR_W+2:0]  err_sum;

    assign a = vec_q[0];
    assign b = vec_q[1];

    // Truth table for the current vector versus what the bank reports; bit order matches fail_mask.
    always_comb begin
        expected = {a ^ b, a | b, a & b, ~(a & b), ~a};
        observed = {bus.abxor, bus.abor, bus.aband, bus.abnand, bus.anot};
        mism     = expected ^ observed;
        pop      = 3'(mism[0]) + 3'(mism[1]) + 3'(mism[2]) + 3'(mism[3]) + 3'(mism[4]);
        err_sum  = (ERR_W+3)'(err_q) + (ERR_W+3)'(pop);
    end

    // Next-state and datapath updates; everything holds unless the state says otherwise.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        scnt_d  = scnt_q;
        pcnt_d  = pcnt_q;
        err_d   = err_q;
        mask_d  = mask_q;
`ifdef GATE_CHK_FIRST_FAIL_EN
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;
        ffobs_d = ffobs_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                // A restart from DONE clears the previous results in the same edge.
                if (bus.start) begin
                    state_d = SETTLE;
                    vec_d   = 2'd0;
                    pcnt_d  = '0;
                    err_d   = '0;
                    mask_d  = '0;
                    scnt_d  = SETTLE_LOAD;
`ifdef GATE_CHK_FIRST_FAIL_EN
                    ffv_d   = 1'b0;
                    ffvec_d = 2'd0;
                    ffobs_d = 5'd0;
`endif
                end
            end
            SETTLE: begin
                if (scnt_q == '0) begin
                    state_d = CHECK;
                end else begin
                    scnt_d = scnt_q - SW'(1);
                end
            end
            CHECK: begin
                mask_d = mask_q | mism;
                // Saturate rather than wrap so a huge failure count never reads as a small one.
                if (|err_sum[ERR_W+2:ERR_W]) begin
                    err_d = '1;
                end else begin
                    err_d = err_sum[ERR_W-1:0];
                end
`ifdef GATE_CHK_FIRST_FAIL_EN
                if (!ffv_q && (mism != 5'd0)) begin
                    ffv_d   = 1'b1;
                    ffvec_d = vec_q;
                    ffobs_d = observed;
                end
`endif
                if ((vec_q == 2'd3) && (pcnt_q == PASS_LAST)) begin
                    state_d = DONE;
                end else begin
                    vec_d  = vec_q + 2'd1;
                    if (vec_q == 2'd3) begin
                        pcnt_d = pcnt_q + PW'(1);
                    end
                    scnt_d  = SETTLE_LOAD;
                    state_d = SETTLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= 2'd0;
            scnt_q  <= '0;
            pcnt_q  <= '0;
            err_q   <= '0;
            mask_q  <= '0;
`ifdef GATE_CHK_FIRST_FAIL_EN
            ffv_q   <= 1'b0;
            ffvec_q <= 2'd0;
            ffobs_q <= 5'd0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            scnt_q  <= scnt_d;
            pcnt_q  <= pcnt_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
`ifdef GATE_CHK_FIRST_FAIL_EN
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
            ffobs_q <= ffobs_d;
`endif
        end
    end

    assign bus.a_out = vec_q[0];
    assign bus.b_out = vec_q[1];
    assign bus.busy  = (state_q == SETTLE) || (state_q == CHECK);
    assign bus.done  = (state_q == DONE);
    assign bus.pass  = (state_q == DONE) && (err_q == '0);
    assign err_count = err_q;
    assign fail_mask = mask_q;
    assign cur_vec   = vec_q;
`ifdef GATE_CHK_FIRST_FAIL_EN
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_obs   = ffobs_q;
`endif

endmodule

// File: tb/tb_gate_resp_checker.sv
// tb/tb_gate_resp_checker.sv - directed self-checking bench for gate_resp_checker

module tb_gate_resp_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Gate bank behaviour per instance: 0 correct, 1 abxor stuck at 0, 2 all outputs inverted.
    logic [1:0] mode0 = 2'd0;
    logic [1:0] mode1 = 2'd0;
    logic [1:0] mode2 = 2'd0;

    // Expected {a_out,b_out} for vec 0..3.
    logic [1:0] ab_tab [0:3] = '{2'b00, 2'b10, 2'b01, 2'b11};

    gate_resp_checker_if g0 ();
    gate_resp_checker_if g1 ();
    gate_resp_checker_if g2 ();

    logic [7:0] err0, err1, err2;
    logic [4:0] mask0, mask1, mask2;
    logic [1:0] vec0, vec1, vec2;
`ifdef GATE_CHK_FIRST_FAIL_EN
    logic       ffv0, ffv1, ffv2;
    logic [1:0] ffvec0, ffvec1, ffvec2;
    logic [4:0] ffobs0, ffobs1, ffobs2;
`endif

    function automatic logic [4:0] bank(input logic a, input logic b, input logic [1:0] mode);
        logic [4:0] r;
        r = {a ^ b, a | b, a & b, ~(a & b), ~a};
        if (mode == 2'd1) r[4] = 1'b0;
        else if (mode == 2'd2) r = ~r;
        return r;
    endfunction

    assign {g0.abxor, g0.abor, g0.aband, g0.abnand, g0.anot} = bank(g0.a_out, g0.b_out, mode0);
    assign {g1.abxor, g1.abor, g1.aband, g1.abnand, g1.anot} = bank(g1.a_out, g1.b_out, mode1);
    assign {g2.abxor, g2.abor, g2.aband, g2.abnand, g2.anot} = bank(g2.a_out, g2.b_out, mode2);

    gate_resp_checker dut0 (
        .clk(clk), .rst(rst), .bus(g0), .err_count(err0), .fail_mask(mask0), .cur_vec(vec0)
`ifdef GATE_CHK_FIRST_FAIL_EN
        , .first_fail_valid(ffv0), .first_fail_vec(ffvec0), .first_fail_obs(ffobs0)
`endif
    );

    gate_resp_checker #(.PASSES(60)) dut1 (
        .clk(clk), .rst(rst), .bus(g1), .err_count(err1), .fail_mask(mask1), .cur_vec(vec1)
`ifdef GATE_CHK_FIRST_FAIL_EN
        , .first_fail_valid(ffv1), .first_fail_vec(ffvec1), .first_fail_obs(ffobs1)
`endif
    );

    gate_resp_checker #(.SETTLE_CYCLES(3)) dut2 (
        .clk(clk), .rst(rst), .bus(g2), .err_count(err2), .fail_mask(mask2), .cur_vec(vec2)
`ifdef GATE_CHK_FIRST_FAIL_EN
        , .first_fail_valid(ffv2), .first_fail_vec(ffvec2), .first_fail_obs(ffobs2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        g0.start = 1'b1; g1.start = 1'b1; g2.start = 1'b1;
        rst = 1'b1;
        tick(); tick();
        n_vec++;
        if ({g0.busy, g0.done, g0.pass, g0.a_out, g0.b_out, vec0, err0, mask0} !== 20'd0) begin
            n_miss++;
            $display("FAIL reset_dut0: got %h want 0", {g0.busy, g0.done, g0.pass, g0.a_out, g0.b_out, vec0, err0, mask0});
        end
        n_vec++;
        if ({g1.busy, g1.done, err1, mask1, g2.busy, g2.done, err2, mask2} !== 30'd0) begin
            n_miss++;
            $display("FAIL reset_dut12: got %h want 0", {g1.busy, g1.done, err1, mask1, g2.busy, g2.done, err2, mask2});
        end
`ifdef GATE_CHK_FIRST_FAIL_EN
        n_vec++;
        if ({ffv0, ffvec0, ffobs0} !== 8'd0) begin
            n_miss++;
            $display("FAIL reset_first_fail: got %h want 0", {ffv0, ffvec0, ffobs0});
        end
`endif
        g0.start = 1'b0; g1.start = 1'b0; g2.start = 1'b0;
        rst = 1'b0;
        tick();
        n_vec++;
        if ({g0.busy, g0.done} !== 2'b00) begin
            n_miss++;
            $display("FAIL idle_after_reset: got %b want 00", {g0.busy, g0.done});
        end
    endtask

    task automatic test_correct_bank();
        mode0 = 2'd0;
        g0.start = 1'b1;
        tick();
        g0.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if ({g0.a_out, g0.b_out, vec0, g0.busy, g0.done} !== {ab_tab[k/2], 2'(k/2), 2'b10}) begin
                n_miss++;
                $display("FAIL correct_seq[%0d]: got %b want %b", k,
                         {g0.a_out, g0.b_out, vec0, g0.busy, g0.done}, {ab_tab[k/2], 2'(k/2), 2'b10});
            end
            tick();
        end
        n_vec++;
        if ({g0.done, g0.pass, g0.busy, err0, mask0} !== {3'b110, 8'd0, 5'd0}) begin
            n_miss++;
            $display("FAIL correct_result: got %h want %h", {g0.done, g0.pass, g0.busy, err0, mask0}, {3'b110, 8'd0, 5'd0});
        end
    endtask

    task automatic test_xor_stuck();
        int i;
        mode0 = 2'd1;
        g0.start = 1'b1;
        tick();
        g0.start = 1'b0;
        for (i = 0; i < 20 && !g0.done; i++) tick();
        n_vec++;
        if (i !== 8) begin
            n_miss++;
            $display("FAIL xor_latency: got %0d want 8", i);
        end
        n_vec++;
        if ({g0.pass, err0, mask0} !== {1'b0, 8'd2, 5'b10000}) begin
            n_miss++;
            $display("FAIL xor_result: got %h want %h", {g0.pass, err0, mask0}, {1'b0, 8'd2, 5'b10000});
        end
`ifdef GATE_CHK_FIRST_FAIL_EN
        n_vec++;
        if ({ffv0, ffvec0, ffobs0} !== {1'b1, 2'd1, 5'b01010}) begin
            n_miss++;
            $display("FAIL xor_first_fail: got %h want %h", {ffv0, ffvec0, ffobs0}, {1'b1, 2'd1, 5'b01010});
        end
`endif
    endtask

    task automatic test_saturate();
        int i;
        mode1 = 2'd2;
        g1.start = 1'b1;
        tick();
        g1.start = 1'b0;
        for (i = 0; i < 600 && !g1.done; i++) tick();
        n_vec++;
        if (i !== 480) begin
            n_miss++;
            $display("FAIL sat_latency: got %0d want 480", i);
        end
        n_vec++;
        if ({g1.pass, err1, mask1} !== {1'b0, 8'd255, 5'b11111}) begin
            n_miss++;
            $display("FAIL sat_result: got %h want %h", {g1.pass, err1, mask1}, {1'b0, 8'd255, 5'b11111});
        end
    endtask

    task automatic test_settle3();
        mode2 = 2'd0;
        g2.start = 1'b1;
        tick();
        g2.start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            n_vec++;
            if ({g2.a_out, g2.b_out, vec2, g2.busy, g2.done} !== {ab_tab[k/4], 2'(k/4), 2'b10}) begin
                n_miss++;
                $display("FAIL settle3_seq[%0d]: got %b want %b", k,
                         {g2.a_out, g2.b_out, vec2, g2.busy, g2.done}, {ab_tab[k/4], 2'(k/4), 2'b10});
            end
            g2.start = (k == 5 || k == 9);
            tick();
        end
        g2.start = 1'b0;
        n_vec++;
        if ({g2.done, g2.pass, err2, mask2} !== {2'b11, 8'd0, 5'd0}) begin
            n_miss++;
            $display("FAIL settle3_result: got %h want %h", {g2.done, g2.pass, err2, mask2}, {2'b11, 8'd0, 5'd0});
        end
    endtask

    task automatic test_reset_midrun();
        int i;
        mode0 = 2'd1;
        g0.start = 1'b1;
        tick();
        g0.start = 1'b0;
        for (i = 0; i < 10 && vec0 != 2'd2; i++) tick();
        n_vec++;
        if ({vec0, err0} !== {2'd2, 8'd1}) begin
            n_miss++;
            $display("FAIL midrun_before_rst: got %h want %h", {vec0, err0}, {2'd2, 8'd1});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({g0.busy, g0.done, g0.a_out, g0.b_out, err0, mask0} !== 17'd0) begin
            n_miss++;
            $display("FAIL midrun_after_rst: got %h want 0", {g0.busy, g0.done, g0.a_out, g0.b_out, err0, mask0});
        end
        mode0 = 2'd0;
        g0.start = 1'b1;
        tick();
        g0.start = 1'b0;
        for (i = 0; i < 20 && !g0.done; i++) tick();
        n_vec++;
        if ({g0.done, g0.pass, err0} !== {2'b11, 8'd0}) begin
            n_miss++;
            $display("FAIL midrun_rerun: got %h want %h", {g0.done, g0.pass, err0}, {2'b11, 8'd0});
        end
    endtask

    task automatic test_back_to_back();
        int i;
        mode0 = 2'd1;
        g0.start = 1'b1;
        tick();
        g0.start = 1'b0;
        for (i = 0; i < 20 && !g0.done; i++) tick();
        n_vec++;
        if ({g0.done, err0} !== {1'b1, 8'd2}) begin
            n_miss++;
            $display("FAIL b2b_first_run: got %h want %h", {g0.done, err0}, {1'b1, 8'd2});
        end
        mode0 = 2'd0;
        g0.start = 1'b1;
        tick();
        n_vec++;
        if ({g0.busy, g0.done, g0.a_out, g0.b_out, err0, mask0} !== {2'b10, 2'b00, 8'd0, 5'd0}) begin
            n_miss++;
            $display("FAIL b2b_restart: got %h want %h", {g0.busy, g0.done, g0.a_out, g0.b_out, err0, mask0},
                     {2'b10, 2'b00, 8'd0, 5'd0});
        end
        for (int k = 1; k < 8; k++) tick();
        n_vec++;
        if ({g0.busy, g0.done} !== 2'b10) begin
            n_miss++;
            $display("FAIL b2b_edge7: got %b want 10", {g0.busy, g0.done});
        end
        tick();
        n_vec++;
        if ({g0.done, g0.pass, err0} !== {2'b11, 8'd0}) begin
            n_miss++;
            $display("FAIL b2b_done: got %h want %h", {g0.done, g0.pass, err0}, {2'b11, 8'd0});
        end
        tick();
        n_vec++;
        if ({g0.busy, g0.done, vec0} !== {2'b10, 2'd0}) begin
            n_miss++;
            $display("FAIL b2b_next_run: got %b want 1000", {g0.busy, g0.done, vec0});
        end
        g0.start = 1'b0;
        for (i = 0; i < 20 && !g0.done; i++) tick();
        n_vec++;
        if ({g0.done, g0.pass} !== 2'b11) begin
            n_miss++;
            $display("FAIL b2b_final: got %b want 11", {g0.done, g0.pass});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        g0.start = 1'b0; g1.start = 1'b0; g2.start = 1'b0;
        test_reset();
        test_correct_bank();
        test_xor_stuck();
        test_saturate();
        test_settle3();
        test_reset_midrun();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
